// File: rtl/sram_access_ctrl_pkg.sv
// Shared definitions for the SRAM access controller: FSM state encoding,
// default geometry of the 32x4 series SRAM array and the wait-counter sizing rule.
package sram_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } ctrl_state_t;

    localparam int SRAM_ADDR_W = 5;
    localparam int SRAM_DATA_W = 4;

    // Wait-counter width; an illegal WAIT_CYCLES still yields a 1-bit counter so elaboration reaches its error.
    function automatic int timer_width(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/sram_access_ctrl_timer.sv
// Loadable down-counter that times the mr_/mw_ strobe width; saturates at zero.
module strobe_timer
    import sram_access_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    localparam int CNT_W = timer_width(WAIT_CYCLES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load wins over decrement; decrement stops at zero so the count never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Synchronous initiator for the asynchronous SRAM array: turns single-word requests
// into registered s_/mr_/mw_ strobe sequences with fixed setup, width and hold.
module sram_access_ctrl
    import sram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              s_,
    output logic              mr_,
    output logic              mw_,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int CNT_W = timer_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(WAIT_CYCLES - 1);

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("sram_access_ctrl: WAIT_CYCLES must be >= 1");
        end
    endgenerate

    ctrl_state_t state;
    logic        op_write;
    logic        timer_load;
    logic        timer_dec;
    logic        timer_zero;

    assign timer_load = (state == SETUP);
    assign timer_dec  = (state == STROBE);

    strobe_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .load (timer_load),
        .value(LOAD_VALUE),
        .dec  (timer_dec),
        .zero (timer_zero)
    );

    // Each output is set one edge ahead of the state it belongs to, so every strobe comes straight from a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            op_write  <= 1'b0;
            s_        <= 1'b1;
            mr_       <= 1'b1;
            mw_       <= 1'b1;
            busy      <= 1'b0;
            ack       <= 1'b0;
            rdata     <= '0;
            sram_addr <= '0;
            sram_din  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_write  <= we;
                        sram_addr <= addr;
                        sram_din  <= wdata;
                        s_        <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    mr_   <= op_write;
                    mw_   <= ~op_write;
                    state <= STROBE;
                end
                STROBE: begin
                    if (timer_zero) begin
                        mr_ <= 1'b1;
                        mw_ <= 1'b1;
                        ack <= 1'b1;
                        if (!op_write) begin
                            rdata <= sram_dout;
                        end
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    s_    <= 1'b1;
                    busy  <= 1'b0;
                    ack   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench: default controller driving a two-bank 32x4 SRAM model, plus
// WAIT_CYCLES=1 and 5 builds sharing the same request inputs for timing checks.
module tb_sram_access_ctrl;

    logic       clock;
    logic       reset;
    logic       req;
    logic       we;
    logic [4:0] addr;
    logic [3:0] wdata;

    logic       busy_2, ack_2, s_2, mr_2, mw_2;
    logic [3:0] rdata_2, sram_din_2, sram_dout_2;
    logic [4:0] sram_addr_2;

    logic       busy_1, ack_1, s_1, mr_1, mw_1;
    logic [3:0] rdata_1, sram_din_1;
    logic [4:0] sram_addr_1;

    logic       busy_5, ack_5, s_5, mr_5, mw_5;
    logic [3:0] rdata_5, sram_din_5;
    logic [4:0] sram_addr_5;

    logic [3:0] fixed_dout;

    int n_checks;
    int n_err;

    logic [31:0] s2v, mr2v, mw2v, ack2v, mr1v, ack1v, mr5v, ack5v;
    logic [3:0]  rd_at_ack;
    logic [3:0]  ref_mem [0:31];
    logic [3:0]  bank_lo [0:15];
    logic [3:0]  bank_hi [0:15];

    sram_access_ctrl #(.WAIT_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy_2), .ack(ack_2), .rdata(rdata_2), .s_(s_2), .mr_(mr_2), .mw_(mw_2),
        .sram_addr(sram_addr_2), .sram_din(sram_din_2), .sram_dout(sram_dout_2)
    );

    sram_access_ctrl #(.WAIT_CYCLES(1)) dut_w1 (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy_1), .ack(ack_1), .rdata(rdata_1), .s_(s_1), .mr_(mr_1), .mw_(mw_1),
        .sram_addr(sram_addr_1), .sram_din(sram_din_1), .sram_dout(fixed_dout)
    );

    sram_access_ctrl #(.WAIT_CYCLES(5)) dut_w5 (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy_5), .ack(ack_5), .rdata(rdata_5), .s_(s_5), .mr_(mr_5), .mw_(mw_5),
        .sram_addr(sram_addr_5), .sram_din(sram_din_5), .sram_dout(fixed_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign fixed_dout = 4'h5;

    // Two 16x4 banks in series: address bit 4 picks the upper bank.
    always_comb begin
        sram_dout_2 = 4'h0;
        if (!s_2 && !mr_2) begin
            sram_dout_2 = sram_addr_2[4] ? bank_hi[sram_addr_2[3:0]] : bank_lo[sram_addr_2[3:0]];
        end
    end

    always @(posedge mw_2) begin
        if (!s_2) begin
            if (sram_addr_2[4]) bank_hi[sram_addr_2[3:0]] = sram_din_2;
            else                bank_lo[sram_addr_2[3:0]] = sram_din_2;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected per-cycle activity: bit c set when cycle c after the accepting edge is at phase lo..hi.
    function automatic logic [31:0] exp_vec(input int w, input int n, input int lo, input int hi, input bit rep);
        logic [31:0] v;
        v = '0;
        for (int c = 1; c <= n; c++) begin
            int p;
            p = (c - 1) % (w + 3);
            if ((rep || c <= w + 3) && p >= lo && p <= hi) v[c] = 1'b1;
        end
        return v;
    endfunction

    task automatic apply_stimulus(input logic w, input logic [4:0] a, input logic [3:0] d, input bit keep);
        @(negedge clock);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        if (w) ref_mem[a] = d;
        @(posedge clock);
        #1;
        req = keep;
    endtask

    task automatic check_output(input int n, input int pulse_at, input bit keep);
        s2v = '0; mr2v = '0; mw2v = '0; ack2v = '0;
        mr1v = '0; ack1v = '0; mr5v = '0; ack5v = '0;
        rd_at_ack = 4'hx;
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            s2v[c]   = ~s_2;
            mr2v[c]  = ~mr_2;
            mw2v[c]  = ~mw_2;
            ack2v[c] = ack_2;
            mr1v[c]  = ~mr_1;
            ack1v[c] = ack_1;
            mr5v[c]  = ~mr_5;
            ack5v[c] = ack_5;
            if (ack_2) rd_at_ack = rdata_2;
            req = keep || (c == pulse_at);
            if (c == pulse_at) begin
                we   = 1'b0;
                addr = 5'h07;
            end
        end
        req = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_s", {31'b0, s_2}, 32'd1);
        check("reset_mr", {31'b0, mr_2}, 32'd1);
        check("reset_mw", {31'b0, mw_2}, 32'd1);
        check("reset_busy", {31'b0, busy_2}, 32'd0);
        check("reset_ack", {31'b0, ack_2}, 32'd0);
        check("reset_rdata", {28'b0, rdata_2}, 32'd0);
        check("reset_sram_addr", {27'b0, sram_addr_2}, 32'd0);
        reset = 1'b0;

        apply_stimulus(1'b1, 5'h13, 4'hA, 1'b0);
        check_output(10, 0, 1'b0);
        check("wr_ack_cycle", ack2v, exp_vec(2, 10, 3, 3, 1'b0));
        check("wr_s_low", s2v, exp_vec(2, 10, 0, 3, 1'b0));
        check("wr_mw_low", mw2v, exp_vec(2, 10, 1, 2, 1'b0));
        check("wr_mr_quiet", mr2v, 32'd0);
        check("wr_rdata_kept", {28'b0, rdata_2}, 32'd0);

        apply_stimulus(1'b0, 5'h13, 4'h0, 1'b0);
        check_output(10, 0, 1'b0);
        check("rd_ack_cycle", ack2v, exp_vec(2, 10, 3, 3, 1'b0));
        check("rd_mr_low", mr2v, exp_vec(2, 10, 1, 2, 1'b0));
        check("rd_mw_quiet", mw2v, 32'd0);
        check("rd_data_at_ack", {28'b0, rd_at_ack}, {28'b0, ref_mem[5'h13]});

        apply_stimulus(1'b1, 5'h03, 4'h1, 1'b0);
        check_output(10, 0, 1'b0);
        apply_stimulus(1'b1, 5'h13, 4'h2, 1'b0);
        check_output(10, 0, 1'b0);
        apply_stimulus(1'b0, 5'h13, 4'h0, 1'b0);
        check_output(10, 0, 1'b0);
        check("bank_hi_data", {28'b0, rdata_2}, {28'b0, ref_mem[5'h13]});

        apply_stimulus(1'b0, 5'h03, 4'h0, 1'b0);
        check_output(10, 2, 1'b0);
        check("busy_single_ack", ack2v, exp_vec(2, 10, 3, 3, 1'b0));
        check("busy_single_s", s2v, exp_vec(2, 10, 0, 3, 1'b0));
        check("busy_sram_addr", {27'b0, sram_addr_2}, 32'h03);
        check("bank_lo_data", {28'b0, rdata_2}, {28'b0, ref_mem[5'h03]});

        apply_stimulus(1'b1, 5'h1F, 4'hF, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check("midrst_in_strobe", {31'b0, mw_2}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_mw", {31'b0, mw_2}, 32'd1);
        check("midrst_s", {31'b0, s_2}, 32'd1);
        check("midrst_busy", {31'b0, busy_2}, 32'd0);
        check("midrst_ack_now", {31'b0, ack_2}, 32'd0);
        reset = 1'b0;
        check_output(10, 0, 1'b0);
        check("midrst_no_ack", ack2v, 32'd0);

        apply_stimulus(1'b0, 5'h03, 4'h0, 1'b1);
        check_output(24, 0, 1'b1);
        check("b2b_w2_ack", ack2v, exp_vec(2, 24, 3, 3, 1'b1));
        check("b2b_w2_mr", mr2v, exp_vec(2, 24, 1, 2, 1'b1));
        check("b2b_w1_ack", ack1v, exp_vec(1, 24, 2, 2, 1'b1));
        check("b2b_w1_mr", mr1v, exp_vec(1, 24, 1, 1, 1'b1));
        check("b2b_w5_ack", ack5v, exp_vec(5, 24, 6, 6, 1'b1));
        check("b2b_w5_mr", mr5v, exp_vec(5, 24, 1, 5, 1'b1));
        check("b2b_w2_rdata", {28'b0, rdata_2}, {28'b0, ref_mem[5'h03]});
        check("b2b_w1_rdata", {28'b0, rdata_1}, 32'h5);
        check("b2b_w5_rdata", {28'b0, rdata_5}, 32'h5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
